// File: rtl/adc_sample_sched.sv
// adc_sample_sched: schedules TLC549 conversions, either periodically (run) or
// on demand (snap_req), and publishes the result on smp_data/smp_valid.
// Optional feature: define ADC_SCHED_AVG_EN to take 4 conversions per sample
// and publish their truncated mean; otherwise a single conversion is passed
// through unmodified.
module adc_sample_sched #(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_HZ   = 1000,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       CLOCK_50,
  input  logic       RST,
  input  logic       run,
  input  logic       snap_req,
  input  logic       err_clr,
  output logic       adc_req,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] smp_data,
  output logic       smp_valid,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_overrun
);

  localparam int PERIOD = CLK_HZ / SAMPLE_HZ;
  localparam int PW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);
`ifdef ADC_SCHED_AVG_EN
  localparam int NCONV  = 4;
`else
  localparam int NCONV  = 1;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;
  logic [1:0]    conv_cnt;
  logic          tick;
  logic          last_conv;
  logic          timeout_hit;
  logic          timeout_set;
  logic          overrun_set;

`ifdef ADC_SCHED_AVG_EN
  logic [9:0] acc;
  logic [9:0] acc_next;

  // Mean of four 8-bit samples: drop the two LSBs of the 10-bit sum.
  function automatic logic [7:0] avg4_trunc(input logic [9:0] sum);
    return sum[9:2];
  endfunction

  assign acc_next = acc + {2'b00, adc_data};
`endif

  assign tick        = run && (pcnt == PW'(PERIOD - 1));
  assign last_conv   = (conv_cnt == 2'(NCONV - 1));
  // tcnt holds the number of cycles since adc_req, so the abort lands
  // TIMEOUT_CYC cycles after the request that went unanswered.
  assign timeout_hit = (tcnt == TW'(TIMEOUT_CYC - 1));
  assign timeout_set = (state == WAIT) && !adc_done && timeout_hit;
  assign overrun_set = tick && (state != IDLE);

  // Free-running sample-period counter; held at zero while run is low.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      pcnt <= '0;
    end else if (!run || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Burst sequencer with registered adc_req/busy/smp_valid/smp_data.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      tcnt      <= '0;
      conv_cnt  <= '0;
      adc_req   <= 1'b0;
      busy      <= 1'b0;
      smp_valid <= 1'b0;
      smp_data  <= 8'h00;
`ifdef ADC_SCHED_AVG_EN
      acc       <= '0;
`endif
    end else begin
      adc_req   <= 1'b0;
      smp_valid <= 1'b0;
      case (state)
        IDLE: begin
          // A coincident tick and snap_req still start just one burst.
          if (tick || snap_req) begin
            state    <= REQ;
            adc_req  <= 1'b1;
            busy     <= 1'b1;
            conv_cnt <= '0;
`ifdef ADC_SCHED_AVG_EN
            acc      <= '0;
`endif
          end
        end
        REQ: begin
          state <= WAIT;
          tcnt  <= TW'(1);
        end
        WAIT: begin
          if (adc_done) begin
`ifdef ADC_SCHED_AVG_EN
            acc <= acc_next;
`endif
            if (last_conv) begin
              state     <= DONE;
              smp_valid <= 1'b1;
`ifdef ADC_SCHED_AVG_EN
              smp_data  <= avg4_trunc(acc_next);
`else
              smp_data  <= adc_data;
`endif
            end else begin
              state    <= REQ;
              adc_req  <= 1'b1;
              conv_cnt <= conv_cnt + 1'b1;
            end
          end else if (timeout_hit) begin
            // Abandon the burst; the published sample stays as it was.
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr takes priority.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      err_timeout <= timeout_set || (err_timeout && !err_clr);
      err_overrun <= overrun_set || (err_overrun && !err_clr);
    end
  end

endmodule

// File: tb/tb_adc_sample_sched.sv
// Testbench for adc_sample_sched: randomized driver responses checked against
// a transaction-level model (collected conversions -> expected sample), plus
// directed scenarios for periodic timing, timeout, overrun and reset.
`timescale 1ns/1ps
module tb_adc_sample_sched;

  localparam int CLK_HZ      = 1000;
  localparam int SAMPLE_HZ   = 100;
  localparam int TIMEOUT_CYC = 16;
  localparam int PERIOD      = CLK_HZ / SAMPLE_HZ;
`ifdef ADC_SCHED_AVG_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst, run, snap_req, err_clr;
  logic       adc_req, adc_done, smp_valid, busy, err_timeout, err_overrun;
  logic [7:0] adc_data, smp_data;
  logic       resp_done, man_done;
  logic [7:0] resp_data, man_data;

  assign adc_done = resp_done | man_done;
  assign adc_data = man_done ? man_data : resp_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit resp_en = 1'b0;
  int resp_delay = 1;
  int resp_q[$];
  int conv_q[$];
  int burst_cyc_q[$];
  int last_done_cyc = -100;
  int req_cnt = 0;
  int valid_cnt = 0;
  logic prev_busy = 1'b0;

  adc_sample_sched #(
    .CLK_HZ(CLK_HZ), .SAMPLE_HZ(SAMPLE_HZ), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLOCK_50(clk), .RST(rst), .run(run), .snap_req(snap_req), .err_clr(err_clr),
    .adc_req(adc_req), .adc_done(adc_done), .adc_data(adc_data),
    .smp_data(smp_data), .smp_valid(smp_valid), .busy(busy),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Driver model: answers each adc_req resp_delay cycles later.
  initial begin
    resp_done = 1'b0;
    resp_data = 8'h00;
    forever begin
      @(negedge clk);
      resp_done = 1'b0;
      if (adc_req && resp_en && !rst) begin
        repeat (resp_delay) @(negedge clk);
        if (resp_en && !rst) begin
          if (resp_q.size() > 0) resp_data = 8'(resp_q.pop_front());
          else resp_data = 8'($urandom_range(0, 255));
          resp_done = 1'b1;
          conv_q.push_back(int'(resp_data));
          last_done_cyc = cyc;
        end
      end
    end
  end

  // Reference model: each published sample is the truncated mean of the
  // conversions delivered in its burst, one cycle after the last of them.
  initial begin
    int s;
    int n;
    forever begin
      @(negedge clk);
      if (adc_req) req_cnt++;
      if (adc_req && !prev_busy) burst_cyc_q.push_back(cyc);
      if (smp_valid) begin
        valid_cnt++;
        n = conv_q.size();
        s = 0;
        for (int i = 0; i < n; i++) s += conv_q[i];
        check_val("valid_latency", cyc - last_done_cyc, 1);
        check_val("burst_len", n, NCONV);
        check_val("smp_value", int'(smp_data), s / NCONV);
        conv_q.delete();
      end
      prev_busy = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic goto_cyc(input int t);
    while (cyc < t) step(1);
  endtask

  task automatic pulse_snap();
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget, input string tag);
    for (int i = 0; i < budget && valid_cnt < target; i++) step(1);
    if (valid_cnt < target) check_val(tag, valid_cnt, target);
  endtask

  task automatic wait_start(input int b0, input string tag, output int r);
    for (int i = 0; i < 200 && burst_cyc_q.size() <= b0; i++) step(1);
    check_val(tag, int'(burst_cyc_q.size() > b0), 1);
    r = (burst_cyc_q.size() > b0) ? burst_cyc_q[b0] : cyc;
  endtask

  initial begin
    int c, r, b0, v0, r0, prev;
    int exp_first;
    rst = 1'b1; run = 1'b0; snap_req = 1'b0; err_clr = 1'b0;
    man_done = 1'b0; man_data = 8'h00;
    step(3);
    check_val("rst_smp_data", int'(smp_data), 0);
    check_val("rst_smp_valid", int'(smp_valid), 0);
    check_val("rst_adc_req", int'(adc_req), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_err_timeout", int'(err_timeout), 0);
    check_val("rst_err_overrun", int'(err_overrun), 0);
    rst = 1'b0;
    step(2);

    // On-demand sample with run low
    resp_en = 1'b1; resp_delay = 2;
    for (int i = 0; i < NCONV; i++) resp_q.push_back(8'hA5);
    r0 = req_cnt; v0 = valid_cnt;
    pulse_snap();
    wait_valid(v0 + 1, 100, "snap_valid_timeout");
    check_val("snap_smp", int'(smp_data), 8'hA5);
    check_val("snap_reqs", req_cnt - r0, NCONV);
    step(50);
    check_val("snap_quiet", req_cnt - r0, NCONV);
    check_val("snap_busy", int'(busy), 0);

    // Periodic sampling, four bursts
    resp_delay = 1;
    resp_q.push_back(8'h10); resp_q.push_back(8'h20);
    resp_q.push_back(8'h30); resp_q.push_back(8'h41);
`ifdef ADC_SCHED_AVG_EN
    exp_first = 8'h28;
`else
    exp_first = 8'h10;
`endif
    b0 = burst_cyc_q.size(); v0 = valid_cnt;
    c = cyc;
    run = 1'b1;
    wait_valid(v0 + 1, 100, "per_valid_timeout");
    check_val("per_first_smp", int'(smp_data), exp_first);
    wait_valid(v0 + 4, 200, "per_valid4_timeout");
    run = 1'b0;
    step(20);
    check_val("per_bursts", burst_cyc_q.size() - b0, 4);
    for (int k = 0; k < 4 && b0 + k < burst_cyc_q.size(); k++)
      check_val("per_start_cyc", burst_cyc_q[b0 + k], c + PERIOD * (k + 1));
    check_val("per_overrun", int'(err_overrun), 0);
    resp_q.delete();

    // Timeout: driver never answers
    prev = int'(smp_data);
    v0 = valid_cnt;
    resp_en = 1'b0;
    b0 = burst_cyc_q.size();
    pulse_snap();
    wait_start(b0, "to_start_seen", r);
    goto_cyc(r + TIMEOUT_CYC - 1);
    check_val("to_early", int'(err_timeout), 0);
    goto_cyc(r + TIMEOUT_CYC);
    check_val("to_flag", int'(err_timeout), 1);
    check_val("to_busy", int'(busy), 0);
    check_val("to_smp_kept", int'(smp_data), prev);
    check_val("to_no_valid", valid_cnt - v0, 0);
    pulse_clr();
    check_val("to_clr", int'(err_timeout), 0);
    conv_q.delete();

    // Overrun: slow driver while periodic ticks keep coming
    resp_en = 1'b1; resp_delay = 12;
    b0 = burst_cyc_q.size(); v0 = valid_cnt;
    c = cyc;
    run = 1'b1;
    wait_start(b0, "ovr_start_seen", r);
    check_val("ovr_start_cyc", r, c + PERIOD);
    goto_cyc(r + PERIOD);
    check_val("ovr_flag", int'(err_overrun), 1);
    run = 1'b0;
    wait_valid(v0 + 1, 200, "ovr_valid_timeout");
    step(40);
    check_val("ovr_bursts", burst_cyc_q.size() - b0, 1);
    check_val("ovr_valids", valid_cnt - v0, 1);
    check_val("ovr_sticky", int'(err_overrun), 1);
    pulse_clr();
    check_val("ovr_clr", int'(err_overrun), 0);

    // Reset in the middle of WAIT
    resp_en = 1'b0;
    b0 = burst_cyc_q.size();
    pulse_snap();
    wait_start(b0, "rstw_start_seen", r);
    goto_cyc(r + 3);
    v0 = valid_cnt; r0 = req_cnt;
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    conv_q.delete();
    man_data = 8'h77; man_done = 1'b1;
    step(1);
    man_done = 1'b0;
    step(20);
    check_val("rstw_no_valid", valid_cnt - v0, 0);
    check_val("rstw_no_req", req_cnt - r0, 0);
    check_val("rstw_smp_data", int'(smp_data), 0);
    check_val("rstw_busy", int'(busy), 0);
    check_val("rstw_adc_req", int'(adc_req), 0);
    check_val("rstw_smp_valid", int'(smp_valid), 0);
    check_val("rstw_err_timeout", int'(err_timeout), 0);
    check_val("rstw_err_overrun", int'(err_overrun), 0);

    // Tick and snap_req in the same IDLE cycle
    resp_en = 1'b1; resp_delay = 1;
    b0 = burst_cyc_q.size(); v0 = valid_cnt;
    c = cyc;
    run = 1'b1;
    goto_cyc(c + PERIOD - 1);
    snap_req = 1'b1;
    step(1);
    snap_req = 1'b0;
    run = 1'b0;
    wait_valid(v0 + 1, 100, "sim_valid_timeout");
    step(30);
    check_val("sim_bursts", burst_cyc_q.size() - b0, 1);
    check_val("sim_valids", valid_cnt - v0, 1);
    check_val("sim_overrun", int'(err_overrun), 0);
    if (burst_cyc_q.size() > b0) check_val("sim_start_cyc", burst_cyc_q[b0], c + PERIOD);

    // Randomized on-demand bursts, with a snap_req ignored while busy
    b0 = burst_cyc_q.size();
    for (int i = 0; i < 12; i++) begin
      resp_delay = $urandom_range(1, 6);
      step($urandom_range(0, 5));
      v0 = valid_cnt;
      pulse_snap();
      step(1);
      pulse_snap();
      wait_valid(v0 + 1, 150, "rnd_valid_timeout");
      step(2);
    end
    check_val("rnd_bursts", burst_cyc_q.size() - b0, 12);
    check_val("rnd_overrun", int'(err_overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_sample_sched.md
ADC_SAMPLE_SCHED -- requirements
Module: adc_sample_sched

Interface
REQ-001 Parameter CLK_HZ, default 50000000, SHALL give the system clock frequency in Hz.
REQ-002 Parameter SAMPLE_HZ, default 1000, SHALL give the periodic sample rate; PERIOD = CLK_HZ/SAMPLE_HZ cycles, integer division.
REQ-003 Parameter TIMEOUT_CYC, default 4096, SHALL bound the wait for one conversion.
REQ-004 Clock and reset SHALL be one clock CLOCK_50 and an asynchronous, active-high reset RST.
REQ-005 Ports SHALL be, in order:
- CLOCK_50  in  1  system clock
- RST  in  1  async active-high reset
- run  in  1  enables periodic sampling
- snap_req  in  1  one-cycle pulse requesting an immediate sample
- err_clr  in  1  one-cycle pulse clearing sticky flags
- adc_req  out  1  one-cycle conversion start to the TLC549 driver
- adc_done  in  1  one-cycle pulse, adc_data valid this cycle
- adc_data  in  8  conversion result
- smp_data  out  8  last published sample
- smp_valid  out  1  one-cycle pulse when smp_data updates
- busy  out  1  high while a burst is in progress
- err_timeout  out  1  sticky: conversion timed out
- err_overrun  out  1  sticky: periodic tick arrived while busy

Function
REQ-006 The period counter SHALL count 0..PERIOD-1 while run=1, emitting an internal tick on the cycle it wraps from PERIOD-1 to 0; while run=0 it SHALL be held at 0 with no tick.
REQ-007 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
REQ-008 In IDLE, a tick or snap_req SHALL move the FSM to REQ; tick and snap_req in the same cycle SHALL start exactly one burst.
REQ-009 REQ SHALL assert adc_req for exactly one cycle, then go to WAIT.
REQ-010 WAIT SHALL accept adc_data on adc_done and go to REQ if more conversions remain in the burst, else to DONE.
REQ-011 A burst SHALL be NCONV conversions: 4 with ADC_SCHED_AVG_EN, 1 without.
REQ-012 DONE SHALL load smp_data, pulse smp_valid for one cycle, and return to IDLE; the latency from the last adc_done to smp_valid SHALL be 1 cycle.
REQ-013 busy SHALL be high in REQ, WAIT and DONE and low in IDLE.
REQ-014 A tick while busy=1 SHALL be dropped and SHALL set err_overrun; snap_req while busy=1 SHALL be ignored without a flag.
REQ-015 If TIMEOUT_CYC cycles elapse in WAIT without adc_done, the burst SHALL be aborted to IDLE, err_timeout set, and smp_data and smp_valid left unchanged; the timeout counter SHALL restart on every REQ.
REQ-016 adc_done outside WAIT SHALL be ignored.
REQ-017 err_clr SHALL clear both sticky flags; if a set condition occurs in the same cycle, set SHALL win.
REQ-018 Deasserting run mid-burst SHALL NOT abort the burst.

Reset
REQ-019 On RST asserted, the block SHALL go immediately to IDLE and SHALL clear the period counter, timeout counter, conversion count, accumulator, smp_data=0x00, smp_valid=0, adc_req=0, busy=0, err_timeout=0 and err_overrun=0.
REQ-020 If RST is asserted mid-burst, no smp_valid SHALL follow release; the first burst SHALL start only on a new tick or snap_req.

Configuration
REQ-021 With macro ADC_SCHED_AVG_EN defined, the block SHALL accumulate 4 conversions in a 10-bit sum and publish smp_data = sum[9:2], truncating.
REQ-022 Without ADC_SCHED_AVG_EN, the block SHALL publish the single conversion unmodified, and no accumulator logic SHALL be present.

Verification
REQ-023 Run every scenario with CLK_HZ=1000 and SAMPLE_HZ=100 (PERIOD=10) and TIMEOUT_CYC=16.
REQ-024 Periodic, AVG_EN, run=1, driver returns 0x10,0x20,0x30,0x41 -> smp_data=0x28 with one smp_valid pulse, 1 cycle after the 4th adc_done; the next burst starts 10 cycles after the first tick.
REQ-025 No AVG_EN, run=0, snap_req pulse, driver returns 0xA5 -> exactly one adc_req, smp_data=0xA5, no further adc_req for 50 cycles.
REQ-026 Timeout: adc_done never asserted -> err_timeout=1 at 16 cycles after adc_req, busy=0, smp_data keeps its prior value; err_clr -> err_timeout=0.
REQ-027 Overrun: driver delays adc_done 12 cycles with run=1 -> err_overrun=1, the dropped tick produces no extra burst, and the burst completes normally.
REQ-028 Reset mid-WAIT: assert RST for 2 cycles, then send adc_done -> no smp_valid, all outputs at reset values.
REQ-029 Simultaneous tick and snap_req in IDLE -> exactly one burst and one smp_valid, err_overrun=0.
